// File: rtl/mkgauss_poly_stream.sv
// Falcon keygen small-polynomial sampler: each coefficient sums 2^(10-logn) CDT base samples,
// then passes a magnitude bound and, on the last coefficient, an f(1)-odd parity check.
module mkgauss_poly_stream #(
  parameter int LOGN_MAX  = 10,
  parameter int OUT_W     = 8,
  parameter int BOUND     = 127,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [3:0]          logn,
  input  logic                abort,
  input  logic                rng_valid,
  input  logic [127:0]        rng_data,
  output logic                rng_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic [LOGN_MAX-1:0] out_idx,
  output logic                out_last,
  output logic                busy,
  output logic                done,
  output logic                cfg_err,
  output logic [15:0]         rej_cnt
);

  localparam int CNT_W = 10;
  localparam logic [CNT_W:0]      G_ONE   = 1;
  localparam logic [LOGN_MAX:0]   N_ONE   = 1;
  localparam logic [LOGN_MAX-1:0] IDX_ONE = 1;
  localparam logic signed [15:0]  BOUND_S = 16'(BOUND);

  // Falcon N=1024 / q=12289 CDT, scaled by 2^63. Entries 1..26 are strictly decreasing.
  localparam logic [62:0] CDT [27] = '{
    63'd1283868770400643928, 63'd6416574995475331444, 63'd4078260278032692663,
    63'd2353523259288686585, 63'd1227179971273316331, 63'd575931623374121527,
    63'd242543240509105209,  63'd91437049221049666,   63'd30799446349977173,
    63'd9255276791179340,    63'd2478152334826140,    63'd590642893610164,
    63'd125206034929641,     63'd23590435911403,      63'd3948334035941,
    63'd586753615614,        63'd77391054539,         63'd9056793210,
    63'd940121950,           63'd86539696,            63'd7062824,
    63'd510971,              63'd32764,               63'd1862,
    63'd94,                  63'd4,                   63'd0
  };

  typedef enum logic [2:0] {S_IDLE, S_ACC, S_CHK, S_EMIT, S_DONE} state_e;

  state_e                    state_q, state_d;
  logic [3:0]                logn_q, logn_d;
  logic signed [15:0]        acc_q, acc_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [LOGN_MAX-1:0]       idx_q, idx_d;
  logic [LOGN_MAX-1:0]       out_idx_q, out_idx_d;
  logic [OUT_W-1:0]          out_data_q, out_data_d;
  logic                      parity_q, parity_d;
  logic [15:0]               rej_cnt_q, rej_cnt_d;
  logic                      cfg_err_q, cfg_err_d;

  logic [CNT_W:0]            g_full;
  logic [CNT_W-1:0]          g_last;
  logic [LOGN_MAX:0]         n_full;
  logic [LOGN_MAX-1:0]       n_last;
  logic                      logn_ok;
  logic signed [5:0]         beat_s;
  logic                      over_bound;
  logic                      par_fail;
  logic                      unused_bits;

  function automatic logic signed [5:0] base_sample(input logic [127:0] beat);
    logic [4:0] mag;
    mag = 5'd1;
    for (int k = 1; k < 27; k++) begin
      if (beat[126:64] < CDT[k]) mag = mag + 5'd1;
    end
    if (beat[62:0] < CDT[0]) return 6'sd0;
    return beat[63] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  assign g_full      = G_ONE << (4'd10 - logn_q);
  assign g_last      = g_full[CNT_W-1:0] - {{(CNT_W-1){1'b0}}, 1'b1};
  assign n_full      = N_ONE << logn_q;
  assign n_last      = n_full[LOGN_MAX-1:0] - IDX_ONE;
  assign logn_ok     = (logn != 4'd0) && (logn <= 4'(LOGN_MAX));
  assign beat_s      = base_sample(rng_data);
  assign over_bound  = (acc_q > BOUND_S) || (acc_q < -BOUND_S);
  assign par_fail    = PARITY_EN && (idx_q == n_last) && ((parity_q ^ acc_q[0]) == 1'b0);
  assign unused_bits = ^{rng_data[127], g_full[CNT_W], n_full[LOGN_MAX]};

  // NOTE: every always_comb output gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    logn_d     = logn_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    out_idx_d  = out_idx_q;
    out_data_d = out_data_q;
    parity_d   = parity_q;
    rej_cnt_d  = rej_cnt_q;
    cfg_err_d  = 1'b0;

    if (abort) begin
      // Any beat handshaked in this cycle is dropped along with the partial sum.
      state_d = S_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (logn_ok) begin
              state_d   = S_ACC;
              logn_d    = logn;
              idx_d     = '0;
              acc_d     = '0;
              cnt_d     = '0;
              parity_d  = 1'b0;
              rej_cnt_d = '0;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        S_ACC: begin
          if (rng_valid) begin
            acc_d = acc_q + {{10{beat_s[5]}}, beat_s};
            if (cnt_q == g_last) begin
              cnt_d   = '0;
              state_d = S_CHK;
            end else begin
              cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
        end
        S_CHK: begin
          if (over_bound || par_fail) begin
            rej_cnt_d = (rej_cnt_q == 16'hFFFF) ? rej_cnt_q : rej_cnt_q + 16'd1;
            acc_d     = '0;
            cnt_d     = '0;
            state_d   = S_ACC;
          end else begin
            out_data_d = acc_q[OUT_W-1:0];
            out_idx_d  = idx_q;
            state_d    = S_EMIT;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            parity_d = parity_q ^ acc_q[0];
            acc_d    = '0;
            cnt_d    = '0;
            if (idx_q == n_last) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + IDX_ONE;
              state_d = S_ACC;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      logn_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      out_idx_q  <= '0;
      out_data_q <= '0;
      parity_q   <= 1'b0;
      rej_cnt_q  <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      logn_q     <= logn_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      out_idx_q  <= out_idx_d;
      out_data_q <= out_data_d;
      parity_q   <= parity_d;
      rej_cnt_q  <= rej_cnt_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign rng_ready = (state_q == S_ACC);
  assign out_valid = (state_q == S_EMIT);
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = (state_q == S_EMIT) && (out_idx_q == n_last);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign cfg_err   = cfg_err_q;
  assign rej_cnt   = rej_cnt_q;

endmodule
